pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. It drives the write-enables and clears of the four pipeline buffers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- It detects load-use hazards, flushes on taken branches, freezes the pipe while data memory is not ready, and halts the core on a memory timeout.
- It keeps saturating stall and flush performance counters.
- It sits beside the datapath. It reads hazard fields from the IF/ID, ID/EX and EX/MEM buffers and writes only control strobes.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives load-enables/clears of IF/ID, ID/EX, EX/MEM, MEM/WB buffers.
// Latency: strobes are combinational from state and inputs (same cycle); counters/state update on clk.
// Backpressure: a pending data-memory access freezes the whole pipe; a timeout halts it until reset.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_clr,
    output logic             id_ex_we,
    output logic             id_ex_clr,
    output logic             ex_mem_we,
    output logic             mem_wb_clr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic freeze;
    logic lu_hazard;
    logic br_flush;

    // Memory access still outstanding: nothing may move this cycle.
    assign freeze = mem_req & ~mem_ready;

    // Load in EX whose destination (not x0) feeds the instruction in ID.
    assign lu_hazard = id_ex_memread & (id_ex_rd != 5'd0) &
                       ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    // Strobe generation by priority: reset, halt, freeze, branch flush, load-use bubble.
    always_comb begin
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_we   = 1'b1;
        id_ex_clr  = 1'b0;
        ex_mem_we  = 1'b1;
        mem_wb_clr = 1'b0;
        br_flush   = 1'b0;
        if (reset) begin
            // buffers clear themselves on reset; leave strobes at defaults
        end else if (state_q == ST_HALT) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (freeze) begin
            // EX is held, so a taken branch is re-presented after release.
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_we  = 1'b0;
            mem_wb_clr = 1'b1;
        end else if (ex_branch_taken) begin
            // Younger instructions are squashed, so any load-use hazard is moot.
            pc_we     = 1'b1;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            br_flush  = 1'b1;
        end else if (lu_hazard) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_clr = 1'b1;
        end
    end

    // Next-state and memory-wait counting.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd1;
                end else begin
                    wait_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    if (wait_q == TIMEOUT_LIM) begin
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    state_d = ST_RUN;
                    wait_d  = 8'd0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    // Saturating performance counters; halted cycles are not counted as stalls.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!reset && state_q != ST_HALT) begin
            if (!pc_we && stall_q != CNT_MAX) begin
                stall_d = stall_q + CNT_ONE;
            end
            if (br_flush && flush_q != CNT_MAX) begin
                flush_d = flush_q + CNT_ONE;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level reference model.
// Built with a short timeout and narrow counters so halt and saturation are reachable.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    if_id_rs1 = '0;
    logic [4:0]    if_id_rs2 = '0;
    logic          id_ex_memread = 1'b0;
    logic [4:0]    id_ex_rd = '0;
    logic          ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr;
    logic          halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_clr(if_id_clr),
        .id_ex_we(id_ex_we), .id_ex_clr(id_ex_clr), .ex_mem_we(ex_mem_we),
        .mem_wb_clr(mem_wb_clr), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state: halted flag, run of consecutive frozen cycles, event counts.
    bit         m_halt   = 1'b0;
    int         m_consec = 0;
    int         m_stall  = 0;
    int         m_flush  = 0;
    logic [6:0] upd_s;
    logic [6:0] cmp_s;

    // Expected strobes {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr}.
    function automatic logic [6:0] exp_strobes(input logic rst, input logic hlt,
                                               input logic mreq, input logic mrdy,
                                               input logic br, input logic mrd,
                                               input logic [4:0] rd, input logic [4:0] r1,
                                               input logic [4:0] r2);
        logic fz, lu;
        fz = mreq & ~mrdy;
        lu = mrd && (rd != 0) && (rd == r1 || rd == r2);
        if (rst) return 7'b1101010;
        if (hlt) return 7'b0000000;
        if (fz)  return 7'b0000001;
        if (br)  return 7'b1111110;
        if (lu)  return 7'b0001110;
        return 7'b1101010;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advance on each rising edge.
    always @(posedge clk) begin
        upd_s = exp_strobes(reset, m_halt, mem_req, mem_ready, ex_branch_taken,
                            id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2);
        if (reset) begin
            m_halt = 1'b0; m_consec = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halt) begin
            if (!upd_s[6] && m_stall < CMAX) m_stall++;
            if (ex_branch_taken && !(mem_req && !mem_ready) && m_flush < CMAX) m_flush++;
            if (mem_req && !mem_ready) begin
                m_consec++;
                if (m_consec > TO) m_halt = 1'b1;
            end else begin
                m_consec = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_s = exp_strobes(reset, m_halt, mem_req, mem_ready, ex_branch_taken,
                                id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2);
            cmp("m_pc_we",      32'(pc_we),      32'(cmp_s[6]));
            cmp("m_if_id_we",   32'(if_id_we),   32'(cmp_s[5]));
            cmp("m_if_id_clr",  32'(if_id_clr),  32'(cmp_s[4]));
            cmp("m_id_ex_we",   32'(id_ex_we),   32'(cmp_s[3]));
            cmp("m_id_ex_clr",  32'(id_ex_clr),  32'(cmp_s[2]));
            cmp("m_ex_mem_we",  32'(ex_mem_we),  32'(cmp_s[1]));
            cmp("m_mem_wb_clr", 32'(mem_wb_clr), 32'(cmp_s[0]));
            cmp("m_halted",     32'(halted),     32'(m_halt));
            cmp("m_stall_cnt",  32'(stall_cnt),  32'(m_stall));
            cmp("m_flush_cnt",  32'(flush_cnt),  32'(m_flush));
        end
    end

    task automatic idle();
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_memread = 1'b0; id_ex_rd = '0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset cycle: strobes forced to defaults regardless of state.
        reset = 1'b1;
        idle();
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7; mem_req = 1'b1;
        #2;
        cmp("rst_pc_we", 32'(pc_we), 32'd1);
        cmp("rst_if_id_we", 32'(if_id_we), 32'd1);
        cmp("rst_id_ex_clr", 32'(id_ex_clr), 32'd0);
        cmp("rst_mem_wb_clr", 32'(mem_wb_clr), 32'd0);
        step();
        reset = 1'b0;
        idle();
        chk_en = 1'b1;
        #2;
        cmp("rst_halted", 32'(halted), 32'd0);
        cmp("rst_stall", 32'(stall_cnt), 32'd0);
        cmp("rst_flush", 32'(flush_cnt), 32'd0);

        // Load-use on rs2.
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_rs1 = 5'd3;
        #2;
        cmp("lu_pc_we", 32'(pc_we), 32'd0);
        cmp("lu_if_id_we", 32'(if_id_we), 32'd0);
        cmp("lu_id_ex_clr", 32'(id_ex_clr), 32'd1);
        step();
        idle();
        #2;
        cmp("lu_stall", 32'(stall_cnt), 32'd1);
        cmp("lu_after_pc_we", 32'(pc_we), 32'd1);
        cmp("lu_after_id_ex_clr", 32'(id_ex_clr), 32'd0);

        // Load to x0 is never a hazard.
        do_reset();
        id_ex_memread = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0;
        #2;
        cmp("x0_pc_we", 32'(pc_we), 32'd1);
        step();
        idle();
        #2;
        cmp("x0_stall", 32'(stall_cnt), 32'd0);

        // Branch wins over a simultaneous load-use.
        do_reset();
        ex_branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5;
        #2;
        cmp("br_pc_we", 32'(pc_we), 32'd1);
        cmp("br_if_id_clr", 32'(if_id_clr), 32'd1);
        cmp("br_id_ex_clr", 32'(id_ex_clr), 32'd1);
        cmp("br_if_id_we", 32'(if_id_we), 32'd1);
        step();
        idle();
        #2;
        cmp("br_flush", 32'(flush_cnt), 32'd1);
        cmp("br_stall", 32'(stall_cnt), 32'd0);

        // Three frozen cycles with a pending branch, then release.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            cmp("mw_ex_mem_we", 32'(ex_mem_we), 32'd0);
            cmp("mw_mem_wb_clr", 32'(mem_wb_clr), 32'd1);
            cmp("mw_if_id_clr", 32'(if_id_clr), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        #2;
        cmp("mw_rel_ex_mem_we", 32'(ex_mem_we), 32'd1);
        cmp("mw_rel_if_id_clr", 32'(if_id_clr), 32'd1);
        cmp("mw_rel_mem_wb_clr", 32'(mem_wb_clr), 32'd0);
        step();
        idle();
        #2;
        cmp("mw_stall", 32'(stall_cnt), 32'd3);
        cmp("mw_flush", 32'(flush_cnt), 32'd1);

        // Timeout: halt after the fifth consecutive not-ready cycle.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            cmp("to_not_yet_halted", 32'(halted), 32'd0);
            step();
        end
        #2;
        cmp("to_halted", 32'(halted), 32'd1);
        cmp("to_pc_we", 32'(pc_we), 32'd0);
        cmp("to_if_id_we", 32'(if_id_we), 32'd0);
        cmp("to_ex_mem_we", 32'(ex_mem_we), 32'd0);
        cmp("to_mem_wb_clr", 32'(mem_wb_clr), 32'd0);
        cmp("to_stall", 32'(stall_cnt), 32'd5);
        mem_ready = 1'b1;
        step();
        #2;
        cmp("to_sticky", 32'(halted), 32'd1);
        cmp("to_stall_hold", 32'(stall_cnt), 32'd5);
        do_reset();
        #2;
        cmp("to_reset_halted", 32'(halted), 32'd0);
        cmp("to_reset_stall", 32'(stall_cnt), 32'd0);
        cmp("to_reset_pc_we", 32'(pc_we), 32'd1);

        // Stall counter saturation.
        do_reset();
        id_ex_memread = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9;
        repeat (20) step();
        idle();
        #2;
        cmp("sat_stall", 32'(stall_cnt), 32'd15);

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        repeat (4000) begin
            reset           = ($urandom % 64) == 0;
            mem_req         = ($urandom % 4) != 0;
            mem_ready       = ($urandom % 3) == 0;
            ex_branch_taken = ($urandom % 5) == 0;
            id_ex_memread   = ($urandom % 2) == 0;
            id_ex_rd        = 5'($urandom % 4);
            if_id_rs1       = 5'($urandom % 4);
            if_id_rs2       = 5'($urandom % 4);
            step();
        end
        reset = 1'b0;
        idle();
        step();
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
